core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
- Multi-cycle control FSM for the single-issue integer core.
- Fetches one instruction through a req/ack instruction-memory port and holds it in an instruction register (IR).
- Steps the combinational decoder, regfile and ALU through DECODE, EXECUTE and WRITEBACK, then advances the PC.
- Sits between instruction memory and the decoder/datapath; owns the PC, the IR, the retire count and the fault status.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FETCH_TIMEOUT, 16, cycles allowed from imem_req_o rise to imem_ack_i before a bus fault is raised; legal range 1..255.

Ports:
- clk_i  in  1  core clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- imem_req_o  out  1  fetch request; held until acknowledged.
- imem_addr_o  out  32  fetch address; equals pc_o.
- imem_ack_i  in  1  fetch data valid this cycle.
- imem_data_i  in  32  fetched instruction word.
- inst_o  out  32  IR contents, fed to the decoder.
- dec_regfile_wen_i  in  1  decoder write-enable for the current inst_o.
- alu_lat_o  out  1  one-cycle strobe; datapath latches the ALU result.
- regfile_we_o  out  1  gated register-file write strobe.
- pc_o  out  32  current PC.
- retire_o  out  1  one-cycle pulse per completed instruction.
- instret_o  out  32  retired-instruction count.
- halted_o  out  1  FSM is in HALT.
- fault_o  out  2  fault cause: 00 none, 01 illegal opcode, 10 fetch timeout.

Behaviour:
- Reset (rst_i high at an edge), from any state including mid-fetch:
  - state = FETCH, pc_o = RESET_PC, inst_o = 0, instret_o = 0, fault_o = 00, timeout counter = 0.
  - All strobes and imem_req_o are 0 in the cycle after the reset edge.
  - imem_req_o rises on the first edge after rst_i falls.
- FETCH:
  - imem_req_o = 1 and imem_addr_o = pc_o, both held stable until ack.
  - imem_ack_i may arrive in the first request cycle (zero-wait).
  - On ack: IR <= imem_data_i, counter cleared, next state DECODE. imem_req_o is 0 in DECODE.
  - Without ack: counter increments. When the counter reaches FETCH_TIMEOUT-1 with no ack: fault_o <= 10, go to HALT.
  - An ack in that same cycle wins over the timeout.
  - imem_ack_i outside FETCH is ignored.
- DECODE, one cycle. Opcode is inst_o[6:0]:
  - 0110011 (R-type) or 0010011 (I-type): go to EXECUTE.
  - 0000000 (NOP/reset bubble): go to WRITEBACK with the write suppressed.
  - Any other opcode: fault_o <= 01, go to HALT. The PC does not advance and no retire is signalled.
- EXECUTE, one cycle: alu_lat_o = 1, then go to WRITEBACK.
- WRITEBACK, one cycle:
  - regfile_we_o = dec_regfile_wen_i & (inst_o[11:7] != 0), and 0 for the NOP opcode.
  - retire_o = 1; pc_o <= pc_o + 4 (wraps modulo 2^32); instret_o += 1 (wraps).
  - Next state FETCH.
- HALT: terminal, left only by reset.
  - halted_o = 1; all strobes and imem_req_o are 0.
  - pc_o, inst_o and fault_o hold their values.
- Latency:
  - With zero-wait ack, an instruction takes 4 cycles: FETCH, DECODE, EXECUTE, WRITEBACK. retire_o pulses every 4th cycle.
  - Each extra wait cycle adds 1.
- Strobes (alu_lat_o, regfile_we_o, retire_o) are decoded from registered state; never more than one strobe per cycle.

Decomposition:
- Shared package core_pkg holds:
  - state enum: FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3, HALT=4, 3-bit encoding;
  - opcode constants OP_R=7'b0110011, OP_I=7'b0010011, OP_NOP=7'b0000000;
  - fault codes FAULT_NONE, FAULT_ILLEGAL, FAULT_TIMEOUT.
- The fetch timeout counter is the one natural sub-module, fetch_timer. Inputs: clear, count enable. Output: expired flag, width clog2(FETCH_TIMEOUT).

Test Plan:
- Zero-wait stream, ack in the first request cycle, words 0x00208033 (add x0), 0x00500093 (addi x1,5), 0x40208133 (sub x2):
  - retire_o at cycles 4, 8, 12; pc_o goes 0 → 4 → 8 → C.
  - regfile_we_o = 0 for rd=x0, 1 for x1 and x2; instret_o = 3.
- Ack delayed 5 cycles:
  - imem_req_o and imem_addr_o stay stable for 6 cycles.
  - Retire occurs at cycle 9; no strobe fires during the wait.
- Word 0x00000000: retire_o pulses, regfile_we_o and alu_lat_o stay 0, pc_o += 4.
- Word 0x00000063 (branch opcode):
  - fault_o = 01, halted_o = 1, pc_o unchanged.
  - No retire; later acks are ignored.
- No ack with FETCH_TIMEOUT=16: fault_o = 10 after 16 request cycles. A second run acking in cycle 16 must fetch normally.
- rst_i asserted one cycle while in EXECUTE:
  - Next cycle: state FETCH, pc_o = RESET_PC, instret_o = 0.
  - No regfile_we_o or retire_o pulse leaks out.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the core sequencer.
// Holds the FSM state encoding, the opcode constants decoded by the
// sequencer, the fault cause codes and a small opcode helper.
package core_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned FLT_W  = 2;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        WRITEBACK = 3'd3,
        HALT      = 3'd4
    } state_t;

    localparam logic [OPC_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_NOP = 7'b0000000;

    localparam logic [FLT_W-1:0] FAULT_NONE    = 2'b00;
    localparam logic [FLT_W-1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [FLT_W-1:0] FAULT_TIMEOUT = 2'b10;

    // Opcodes that need an ALU cycle before writeback.
    function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
        return (op == OP_R) || (op == OP_I);
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// core_sequencer_if: instruction-memory fetch port (req/ack handshake).
//   req  : fetch request, held until acknowledged (sequencer drives)
//   addr : fetch address (sequencer drives)
//   ack  : fetched word valid this cycle (memory drives)
//   data : fetched instruction word (memory drives)
interface core_sequencer_if;
    import core_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            ack;
    logic [XLEN-1:0] data;

    modport master (output req, output addr, input ack, input data);
    modport slave  (input req, input addr, output ack, output data);

endinterface

// File: rtl/fetch_timer.sv
// fetch_timer: counts cycles of an unacknowledged fetch request.
//   clk       : core clock
//   clear     : synchronous clear (reset, ack, or not fetching)
//   count_en  : advance the count this cycle
//   expired_c : count has reached FETCH_TIMEOUT-1 (combinational)
module fetch_timer #(
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic clk,
    input  logic clear,
    input  logic count_en,
    output logic expired_c
);

    localparam int unsigned CW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(FETCH_TIMEOUT - 1);

    logic [CW-1:0] count;

    // Clear dominates; the sequencer halts on expiry so no wrap handling.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + CW'(1);
        end
    end

    assign expired_c = (count == LAST);

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the single-issue integer core.
// Fetches through a req/ack port into the IR, then steps DECODE, EXECUTE
// and WRITEBACK before advancing the PC.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   imem              : fetch port (req/addr out, ack/data in)
//   inst_o            : IR contents to the decoder
//   dec_regfile_wen_i : decoder write enable for inst_o
//   alu_lat_o         : ALU result latch strobe (EXECUTE)
//   regfile_we_o      : gated register-file write strobe (WRITEBACK)
//   pc_o              : current PC
//   retire_o          : one pulse per completed instruction
//   instret_o         : retired-instruction count
//   halted_o          : FSM is in HALT
//   fault_o           : 00 none, 01 illegal opcode, 10 fetch timeout
module core_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    core_sequencer_if.master      imem,
    output logic [XLEN-1:0]       inst_o,
    input  logic                  dec_regfile_wen_i,
    output logic                  alu_lat_o,
    output logic                  regfile_we_o,
    output logic [XLEN-1:0]       pc_o,
    output logic                  retire_o,
    output logic [XLEN-1:0]       instret_o,
    output logic                  halted_o,
    output logic [FLT_W-1:0]      fault_o
);

    state_t           state;
    logic [OPC_W-1:0] opcode;
    logic             fetching;
    logic             timer_clear;
    logic             timer_en;
    logic             expired;
    logic             wb_we;

    assign opcode    = inst_o[OPC_W-1:0];
    assign imem.addr = pc_o;

    // A fetch is live only once req is up; the post-reset bubble is idle.
    assign fetching    = (state == FETCH) && imem.req;
    assign timer_clear = rst_i || !fetching || imem.ack;
    assign timer_en    = fetching && !imem.ack;

    // Writes to x0 and NOP bubbles never reach the register file.
    assign wb_we = dec_regfile_wen_i && (inst_o[11:7] != 5'd0) && (opcode != OP_NOP);

    fetch_timer #(
        .FETCH_TIMEOUT (FETCH_TIMEOUT)
    ) u_fetch_timer (
        .clk       (clk_i),
        .clear     (timer_clear),
        .count_en  (timer_en),
        .expired_c (expired)
    );

    // Sequencer FSM; every strobe is registered alongside the state change.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= FETCH;
            pc_o         <= RESET_PC;
            inst_o       <= '0;
            instret_o    <= '0;
            fault_o      <= FAULT_NONE;
            imem.req     <= 1'b0;
            alu_lat_o    <= 1'b0;
            regfile_we_o <= 1'b0;
            retire_o     <= 1'b0;
            halted_o     <= 1'b0;
        end else begin
            alu_lat_o    <= 1'b0;
            regfile_we_o <= 1'b0;
            retire_o     <= 1'b0;
            case (state)
                FETCH: begin
                    if (!imem.req) begin
                        imem.req <= 1'b1;
                    end else if (imem.ack) begin
                        // Ack wins over a same-cycle timeout.
                        inst_o   <= imem.data;
                        imem.req <= 1'b0;
                        state    <= DECODE;
                    end else if (expired) begin
                        fault_o  <= FAULT_TIMEOUT;
                        imem.req <= 1'b0;
                        halted_o <= 1'b1;
                        state    <= HALT;
                    end
                end
                DECODE: begin
                    if (is_alu_op(opcode)) begin
                        alu_lat_o <= 1'b1;
                        state     <= EXECUTE;
                    end else if (opcode == OP_NOP) begin
                        retire_o  <= 1'b1;
                        state     <= WRITEBACK;
                    end else begin
                        fault_o   <= FAULT_ILLEGAL;
                        halted_o  <= 1'b1;
                        state     <= HALT;
                    end
                end
                EXECUTE: begin
                    regfile_we_o <= wb_we;
                    retire_o     <= 1'b1;
                    state        <= WRITEBACK;
                end
                WRITEBACK: begin
                    pc_o      <= pc_o + 32'd4;
                    instret_o <= instret_o + 32'd1;
                    imem.req  <= 1'b1;
                    state     <= FETCH;
                end
                HALT: begin
                    halted_o <= 1'b1;
                end
                default: begin
                    imem.req <= 1'b0;
                    halted_o <= 1'b1;
                    state    <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed self-checking bench for core_sequencer.
// Drives the fetch port cycle by cycle and checks every output against
// hand-computed values one cycle at a time.
module tb_core_sequencer;
    import core_pkg::*;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] inst_o;
    logic        dec_regfile_wen_i;
    logic        alu_lat_o;
    logic        regfile_we_o;
    logic [31:0] pc_o;
    logic        retire_o;
    logic [31:0] instret_o;
    logic        halted_o;
    logic [1:0]  fault_o;

    int n_cmp = 0;
    int n_err = 0;

    core_sequencer_if imem_bus ();

    core_sequencer #(
        .RESET_PC      (32'h0000_0000),
        .FETCH_TIMEOUT (16)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .imem              (imem_bus),
        .inst_o            (inst_o),
        .dec_regfile_wen_i (dec_regfile_wen_i),
        .alu_lat_o         (alu_lat_o),
        .regfile_we_o      (regfile_we_o),
        .pc_o              (pc_o),
        .retire_o          (retire_o),
        .instret_o         (instret_o),
        .halted_o          (halted_o),
        .fault_o           (fault_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle_strobes(input string tag);
        check(tag, {29'd0, alu_lat_o, regfile_we_o, retire_o}, 32'd0);
    endtask

    // Entered in the first request cycle; leaves in the next fetch cycle.
    task automatic run_inst(input logic [31:0] word, input int waits, input logic wen,
                            input bit alu_path, input logic exp_we, input logic [31:0] pc_exp);
        for (int i = 0; i < waits; i++) begin
            check("wait_req", {31'd0, imem_bus.req}, 32'd1);
            check("wait_addr", imem_bus.addr, pc_exp);
            check_idle_strobes("wait_strobes");
            tick();
        end
        check("fetch_req", {31'd0, imem_bus.req}, 32'd1);
        check("fetch_addr", imem_bus.addr, pc_exp);
        imem_bus.ack      = 1'b1;
        imem_bus.data     = word;
        dec_regfile_wen_i = wen;
        tick();
        imem_bus.ack  = 1'b0;
        imem_bus.data = 32'hDEAD_BEEF;
        check("dec_req", {31'd0, imem_bus.req}, 32'd0);
        check("dec_inst", inst_o, word);
        check_idle_strobes("dec_strobes");
        tick();
        if (alu_path) begin
            check("exe_strobes", {29'd0, alu_lat_o, regfile_we_o, retire_o}, 32'd4);
            tick();
        end
        check("wb_strobes", {29'd0, alu_lat_o, regfile_we_o, retire_o}, {29'd0, 1'b0, exp_we, 1'b1});
        check("wb_pc", pc_o, pc_exp);
        tick();
        check("next_pc", pc_o, pc_exp + 32'd4);
        check("next_req", {31'd0, imem_bus.req}, 32'd1);
        check_idle_strobes("next_strobes");
    endtask

    initial begin
        rst_i             = 1'b1;
        imem_bus.ack      = 1'b0;
        imem_bus.data     = 32'h0;
        dec_regfile_wen_i = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_req", {31'd0, imem_bus.req}, 32'd0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_inst", inst_o, 32'h0);
        check("rst_instret", instret_o, 32'h0);
        check("rst_fault", {30'd0, fault_o}, 32'd0);
        check("rst_halted", {31'd0, halted_o}, 32'd0);
        check_idle_strobes("rst_strobes");
        rst_i = 1'b0;
        check("bubble_req", {31'd0, imem_bus.req}, 32'd0);
        tick();

        // Zero-wait stream: add x0, addi x1, sub x2
        run_inst(32'h0020_8033, 0, 1'b1, 1'b1, 1'b0, 32'h0);
        run_inst(32'h0050_0093, 0, 1'b1, 1'b1, 1'b1, 32'h4);
        run_inst(32'h4020_8133, 0, 1'b1, 1'b1, 1'b1, 32'h8);
        check("stream_instret", instret_o, 32'd3);
        check("stream_pc", pc_o, 32'hC);

        // Ack delayed by 5 cycles
        run_inst(32'h0050_0093, 5, 1'b1, 1'b1, 1'b1, 32'hC);
        check("delay_instret", instret_o, 32'd4);

        // NOP bubbles, including one with a nonzero rd field
        run_inst(32'h0000_0000, 0, 1'b1, 1'b0, 1'b0, 32'h10);
        run_inst(32'h0000_0080, 0, 1'b1, 1'b0, 1'b0, 32'h14);
        check("nop_instret", instret_o, 32'd6);

        // Illegal (branch) opcode halts without retiring
        imem_bus.ack  = 1'b1;
        imem_bus.data = 32'h0000_0063;
        tick();
        imem_bus.ack = 1'b0;
        check("ill_dec_inst", inst_o, 32'h0000_0063);
        check_idle_strobes("ill_dec_strobes");
        tick();
        check("ill_fault", {30'd0, fault_o}, 32'd1);
        check("ill_halted", {31'd0, halted_o}, 32'd1);
        check("ill_pc", pc_o, 32'h18);
        check("ill_req", {31'd0, imem_bus.req}, 32'd0);
        check_idle_strobes("ill_strobes");
        imem_bus.ack  = 1'b1;
        imem_bus.data = 32'h0050_0093;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_req", {31'd0, imem_bus.req}, 32'd0);
            check("halt_inst", inst_o, 32'h0000_0063);
            check("halt_pc", pc_o, 32'h18);
            check("halt_halted", {31'd0, halted_o}, 32'd1);
            check_idle_strobes("halt_strobes");
        end
        imem_bus.ack = 1'b0;
        check("halt_instret", instret_o, 32'd6);

        // No ack: timeout after 16 request cycles
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("to_rst_fault", {30'd0, fault_o}, 32'd0);
        check("to_rst_halted", {31'd0, halted_o}, 32'd0);
        check("to_rst_pc", pc_o, 32'h0);
        tick();
        for (int i = 1; i <= 16; i++) begin
            check("to_wait_req", {31'd0, imem_bus.req}, 32'd1);
            check("to_wait_halted", {31'd0, halted_o}, 32'd0);
            check("to_wait_fault", {30'd0, fault_o}, 32'd0);
            tick();
        end
        check("to_fault", {30'd0, fault_o}, 32'd2);
        check("to_halted", {31'd0, halted_o}, 32'd1);
        check("to_req", {31'd0, imem_bus.req}, 32'd0);
        check("to_pc", pc_o, 32'h0);

        // Ack in the 16th request cycle beats the timeout
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        run_inst(32'h0050_0093, 15, 1'b1, 1'b1, 1'b1, 32'h0);
        check("ack16_fault", {30'd0, fault_o}, 32'd0);
        check("ack16_halted", {31'd0, halted_o}, 32'd0);
        check("ack16_instret", instret_o, 32'd1);

        // Reset asserted for one cycle during EXECUTE
        imem_bus.ack      = 1'b1;
        imem_bus.data     = 32'h0050_0093;
        dec_regfile_wen_i = 1'b1;
        tick();
        imem_bus.ack = 1'b0;
        tick();
        check("rx_exe_alu", {31'd0, alu_lat_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rx_pc", pc_o, 32'h0);
        check("rx_instret", instret_o, 32'd0);
        check("rx_req", {31'd0, imem_bus.req}, 32'd0);
        check("rx_inst", inst_o, 32'h0);
        check_idle_strobes("rx_strobes");
        tick();
        check("rx_req_rise", {31'd0, imem_bus.req}, 32'd1);
        check_idle_strobes("rx_strobes2");
        run_inst(32'h4020_8133, 0, 1'b1, 1'b1, 1'b1, 32'h0);
        check("rx_instret_after", instret_o, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
